// File: rtl/multi_debouncer_if.sv
`default_nettype none
// ============================================================================
//  Module   : multi_debouncer_if
//  Purpose  : Bundles the raw-input and conditioned-output vectors of the
//             multi-channel debouncer.
//  Ports    : signal      - raw asynchronous inputs, active-high
//             debounced   - debounced level per channel
//             pressed     - one-clock pulse on each 0->1 level change
//             released    - one-clock pulse on each 1->0 level change
//             repeat_tick - one-clock auto-repeat pulse while held
//  Modports : master - board/pin side (drives signal, observes outputs)
//             slave  - debouncer side
//  Revision : 1.0 - initial release
// ============================================================================
interface multi_debouncer_if #(
  parameter int CHANNELS = 5
);
  logic [CHANNELS-1:0] signal;
  logic [CHANNELS-1:0] debounced;
  logic [CHANNELS-1:0] pressed;
  logic [CHANNELS-1:0] released;
  logic [CHANNELS-1:0] repeat_tick;

  modport master (
    output signal,
    input  debounced,
    input  pressed,
    input  released,
    input  repeat_tick
  );

  modport slave (
    input  signal,
    output debounced,
    output pressed,
    output released,
    output repeat_tick
  );
endinterface
`default_nettype wire

// File: rtl/multi_debouncer.sv
`default_nettype none
// ============================================================================
//  Module   : multi_debouncer
//  Purpose  : Synchronises and debounces CHANNELS raw inputs using a shared
//             sample tick and a per-channel stability counter; produces a
//             clean level, press/release pulses and optional auto-repeat.
//  Ports    : clock   - system clock
//             reset_n - asynchronous active-low reset
//             bus     - multi_debouncer_if.slave (signal in, levels/pulses out)
//  Revision : 1.0 - initial release
// ============================================================================
module multi_debouncer #(
  parameter int CHANNELS     = 5,
  parameter int CLK_DIV      = 250000,
  parameter int STABLE_TICKS = 4,
  parameter int REPEAT_DELAY = 100,
  parameter int REPEAT_RATE  = 25
) (
  input  wire logic            clock,
  input  wire logic            reset_n,
  multi_debouncer_if.slave     bus
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int CNT_W = $clog2(STABLE_TICKS + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

  logic [DIV_W-1:0]    div_q, div_d;
  logic                w_tick;
  logic [CHANNELS-1:0] sync1_q, sync2_q;
  logic [CHANNELS-1:0] deb_q, deb_d;
  logic [CHANNELS-1:0] pressed_q, released_q, repeat_q;
  logic [CHANNELS-1:0] w_rise, w_fall, repeat_d;

  // Shared prescaler: tick is a one-clock enable, never a clock.
  always_comb begin
    w_tick = (div_q == DIV_LAST);
    div_d  = w_tick ? '0 : div_q + DIV_W'(1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div_q      <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      pressed_q  <= '0;
      released_q <= '0;
      repeat_q   <= '0;
    end else begin
      div_q      <= div_d;
      sync1_q    <= bus.signal;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      // Edge pulses update on the same edge as the level, so each pulse
      // lines up with the first cycle of the new level.
      pressed_q  <= w_rise;
      released_q <= w_fall;
      repeat_q   <= repeat_d;
    end
  end

  // Per-channel integrator: counts consecutive ticks on which the
  // synchronised input disagrees with the accepted level.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             w_toggle;

    always_comb begin
      cnt_d    = cnt_q;
      w_toggle = 1'b0;
      if (w_tick) begin
        if (sync2_q[i] == deb_q[i]) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d    = '0;
          w_toggle = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign deb_d[i]  = deb_q[i] ^ w_toggle;
    assign w_rise[i] = w_toggle & ~deb_q[i];
    assign w_fall[i] = w_toggle &  deb_q[i];
  end

  if (REPEAT_DELAY > 0) begin : g_repeat
    localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

    localparam logic [HOLD_W-1:0] HOLD_FIRE   = HOLD_W'(REPEAT_DELAY);
    // Reload is taken modulo 2**HOLD_W. When REPEAT_RATE exceeds
    // REPEAT_DELAY the reload wraps above HOLD_FIRE and rolls over through
    // zero, so the next match still lands exactly REPEAT_RATE ticks later.
    localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(REPEAT_DELAY - REPEAT_RATE);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_hold
      logic [HOLD_W-1:0] hold_q, hold_d, w_inc;
      logic              w_fire;

      always_comb begin
        hold_d = hold_q;
        w_fire = 1'b0;
        w_inc  = hold_q + HOLD_W'(1);
        // A level change on this tick restarts the hold phase and
        // suppresses any repeat, including on the falling tick.
        if (w_rise[i] || w_fall[i]) begin
          hold_d = '0;
        end else if (w_tick && deb_q[i]) begin
          if (w_inc == HOLD_FIRE) begin
            w_fire = 1'b1;
            hold_d = HOLD_RELOAD;
          end else begin
            hold_d = w_inc;
          end
        end
      end

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          hold_q <= '0;
        end else begin
          hold_q <= hold_d;
        end
      end

      assign repeat_d[i] = w_fire;
    end
  end else begin : g_no_repeat
    assign repeat_d = '0;
  end

  assign bus.debounced   = deb_q;
  assign bus.pressed     = pressed_q;
  assign bus.released    = released_q;
  assign bus.repeat_tick = repeat_q;

endmodule
`default_nettype wire

// File: tb/tb_multi_debouncer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multi_debouncer
//  Purpose  : Self-checking bench for multi_debouncer: directed scenarios
//             followed by randomized input activity, every cycle compared
//             against a tick/run-length reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multi_debouncer;

  localparam int CH = 2;
  localparam int CD = 4;
  localparam int ST = 3;
  localparam int RD = 5;
  localparam int RR = 2;

  logic clock = 1'b0;
  logic reset_n = 1'b0;

  always #5 clock = ~clock;

  multi_debouncer_if #(.CHANNELS(CH)) bus ();

  multi_debouncer #(
    .CHANNELS    (CH),
    .CLK_DIV     (CD),
    .STABLE_TICKS(ST),
    .REPEAT_DELAY(RD),
    .REPEAT_RATE (RR)
  ) u_dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: clocks since reset, 2-deep input delay, accepted
  // level, run of disagreeing samples, ticks held since rising.
  int          m_cyc;
  logic [CH-1:0] m_d1, m_d2, m_lvl, m_pr, m_rl, m_rp;
  int          m_run [CH];
  int          m_held[CH];

  // Observation window results
  int np[CH], nr[CH], nrep[CH], first_hi[CH], first_lo[CH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs === expv) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_cyc = 0;
    m_d1 = '0; m_d2 = '0; m_lvl = '0;
    m_pr = '0; m_rl = '0; m_rp = '0;
    for (int c = 0; c < CH; c++) begin
      m_run[c]  = 0;
      m_held[c] = 0;
    end
  endtask

  task automatic model_edge();
    logic samp;
    logic rose, fell;
    if (!reset_n) begin
      model_reset();
      return;
    end
    m_cyc++;
    m_pr = '0; m_rl = '0; m_rp = '0;
    for (int c = 0; c < CH; c++) begin
      samp    = m_d2[c];
      m_d2[c] = m_d1[c];
      m_d1[c] = bus.signal[c];
      if (m_cyc % CD == 0) begin
        rose = 1'b0;
        fell = 1'b0;
        if (samp != m_lvl[c]) begin
          m_run[c]++;
          if (m_run[c] == ST) begin
            m_run[c] = 0;
            rose = ~m_lvl[c];
            fell =  m_lvl[c];
            m_lvl[c] = ~m_lvl[c];
          end
        end else begin
          m_run[c] = 0;
        end
        if (rose || fell) begin
          m_held[c] = 0;
        end else if (m_lvl[c]) begin
          m_held[c]++;
          if (m_held[c] >= RD && ((m_held[c] - RD) % RR) == 0) m_rp[c] = 1'b1;
        end
        m_pr[c] = rose;
        m_rl[c] = fell;
      end
    end
  endtask

  task automatic compare_all();
    check("level",   32'(bus.debounced),   32'(m_lvl));
    check("pressed", 32'(bus.pressed),     32'(m_pr));
    check("release", 32'(bus.released),    32'(m_rl));
    check("repeat",  32'(bus.repeat_tick), 32'(m_rp));
  endtask

  task automatic tick_cycle();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    compare_all();
  endtask

  function automatic logic [CH-1:0] outv(input int sel);
    case (sel)
      0:       return bus.debounced;
      1:       return bus.pressed;
      2:       return bus.released;
      default: return bus.repeat_tick;
    endcase
  endfunction

  task automatic observe(input int n);
    for (int c = 0; c < CH; c++) begin
      np[c] = 0; nr[c] = 0; nrep[c] = 0; first_hi[c] = -1; first_lo[c] = -1;
    end
    for (int k = 1; k <= n; k++) begin
      tick_cycle();
      for (int c = 0; c < CH; c++) begin
        np[c]   += int'(bus.pressed[c]);
        nr[c]   += int'(bus.released[c]);
        nrep[c] += int'(bus.repeat_tick[c]);
        if (bus.debounced[c] && first_hi[c] < 0) first_hi[c] = k;
        if (!bus.debounced[c] && first_lo[c] < 0) first_lo[c] = k;
      end
    end
  endtask

  task automatic wait_hi(input string tag, input int sel, input int ch, input int maxc,
                         output int lat);
    logic [CH-1:0] v;
    v   = '0;
    lat = -1;
    for (int k = 1; k <= maxc; k++) begin
      tick_cycle();
      v = outv(sel);
      if (v[ch]) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) check({tag, "_timeout"}, 32'(v[ch]), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int sum_p, sum_r, hi_seen;
    int seg_len;
    int mode[CH];

    bus.signal = 2'b11;
    model_reset();

    // 1. Reset with inputs high, then release
    repeat (3) tick_cycle();
    check("rst_deb", 32'(bus.debounced),   32'd0);
    check("rst_prs", 32'(bus.pressed),     32'd0);
    check("rst_rel", 32'(bus.released),    32'd0);
    check("rst_rep", 32'(bus.repeat_tick), 32'd0);
    reset_n = 1'b1;
    observe(20);
    check("rst_lat0", 32'((first_hi[0] >= 1) && (first_hi[0] <= 14)), 32'd1);
    check("rst_lat1", 32'((first_hi[1] >= 1) && (first_hi[1] <= 14)), 32'd1);
    check("rst_np0", 32'(np[0]), 32'd1);
    check("rst_np1", 32'(np[1]), 32'd1);
    bus.signal = 2'b00;
    observe(20);
    check("drop_nr0", 32'(nr[0]), 32'd1);
    check("drop_nr1", 32'(nr[1]), 32'd1);

    // 2. Clean press/release on ch0
    bus.signal[0] = 1'b1;
    observe(20);
    check("press_lat", 32'((first_hi[0] >= 11) && (first_hi[0] <= 14)), 32'd1);
    check("press_np0", 32'(np[0]), 32'd1);
    check("press_np1", 32'(np[1]), 32'd0);
    bus.signal[0] = 1'b0;
    observe(20);
    check("rel_nr0", 32'(nr[0]), 32'd1);
    check("rel_np0", 32'(np[0]), 32'd0);

    // 3. Bounce rejection: toggle every 6 clocks for 60 clocks
    sum_p = 0; sum_r = 0; hi_seen = 0;
    for (int t = 0; t < 10; t++) begin
      bus.signal[0] = ~bus.signal[0];
      observe(6);
      sum_p += np[0];
      sum_r += nr[0];
      if (first_hi[0] >= 0) hi_seen = 1;
    end
    check("bounce_np",  32'(sum_p),   32'd0);
    check("bounce_nr",  32'(sum_r),   32'd0);
    check("bounce_lvl", 32'(hi_seen), 32'd0);
    bus.signal[0] = 1'b1;
    observe(20);
    check("settle_np0", 32'(np[0]), 32'd1);

    // 4. Auto-repeat on ch1 over 20 hold ticks
    bus.signal[1] = 1'b1;
    wait_hi("rep_press", 1, 1, 20, lat);
    observe(80);
    check("rep_count", 32'(nrep[1]), 32'd8);
    bus.signal[1] = 1'b0;
    wait_hi("rep_release", 2, 1, 20, lat);
    observe(20);
    check("rep_after_fall", 32'(nrep[1]), 32'd0);
    check("rep_no_press",   32'(np[1]),   32'd0);

    // 5. Simultaneous ch0 rise and ch1 fall
    bus.signal[0] = 1'b0;
    observe(20);
    bus.signal[1] = 1'b1;
    observe(20);
    bus.signal = 2'b01;
    wait_hi("sim_press0", 1, 0, 20, lat);
    check("sim_press0", 32'(bus.pressed[0]),  32'd1);
    check("sim_rel1",   32'(bus.released[1]), 32'd1);

    // 6. Asynchronous reset while ch0 is repeating
    wait_hi("mid_rep", 3, 0, 40, lat);
    check("mid_deb0", 32'(bus.debounced[0]), 32'd1);
    @(posedge clock);
    model_edge();
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("async_deb", 32'(bus.debounced),   32'd0);
    check("async_prs", 32'(bus.pressed),     32'd0);
    check("async_rel", 32'(bus.released),    32'd0);
    check("async_rep", 32'(bus.repeat_tick), 32'd0);
    @(negedge clock);
    compare_all();
    repeat (3) tick_cycle();
    reset_n = 1'b1;
    observe(20);
    check("rerst_np0", 32'(np[0]), 32'd1);
    check("rerst_nr0", 32'(nr[0]), 32'd0);
    check("rerst_lat", 32'((first_hi[0] >= 1) && (first_hi[0] <= 14)), 32'd1);

    // 7. Randomized activity: per-channel bouncy / stable-low / stable-high segments
    for (int s = 0; s < 30; s++) begin
      seg_len = int'($urandom_range(8, 100));
      for (int c = 0; c < CH; c++) mode[c] = int'($urandom_range(0, 2));
      for (int k = 0; k < seg_len; k++) begin
        for (int c = 0; c < CH; c++) begin
          case (mode[c])
            0:       if ($urandom_range(0, 2) == 0) bus.signal[c] = ~bus.signal[c];
            1:       bus.signal[c] = 1'b0;
            default: bus.signal[c] = 1'b1;
          endcase
        end
        tick_cycle();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
